// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data_mem (256 x 32, byte-masked clocked store,
// combinational read) between the pipeline's MEM-stage load/store unit (CPU
// port) and a word-wide DMA/loader port.
//
// The CPU port is the normal priority winner. A streak counter tracks
// consecutive CPU grants taken while DMA is waiting. When that streak reaches
// STARVE_LIMIT, the next contested cycle goes to DMA.
//
// CPU accesses are converted from a byte address plus size into:
//   - a word index,
//   - a byte mask,
//   - lane-replicated store data.
// Load data returns one cycle after the grant, shifted down to bit 0 and
// zero-extended to the access size.
//
// Optional feature:
//   DMEM_ARB_MISALIGN_TRAP_EN  - when defined, a misaligned half or word CPU
//                                access is consumed without touching memory.
//                                The following cycle reports misalign_err
//                                with cpu_rdata = 0. When undefined,
//                                misalign_err is tied low and the low address
//                                bits are simply ignored.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   cpu_req/we/size/addr/wdata  CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_stall          same-cycle grant / stall to hazard unit
//   cpu_rvalid, cpu_rdata       one-cycle load result pulse, aligned data
//   misalign_err                misaligned-access pulse (trap build only)
//   dma_req/we/addr/be/wdata    DMA request (held until dma_gnt)
//   dma_gnt                     same-cycle grant
//   dma_rvalid, dma_rdata       one-cycle load result pulse, full word
//   mem_store, mem_load, mem_mask, mem_address, mem_wdata, mem_rdata
//                               data_mem side; address is a word index
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        misalign_err,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [3:0]  dma_be,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,

  output logic        mem_store,
  output logic        mem_load,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [0:0] {
    S_CPU       = 1'b0,
    S_FORCE_DMA = 1'b1
  } state_t;

  localparam logic [3:0] STARVE_LIMIT_C = STARVE_LIMIT[3:0];

  // ---------------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------------

  // Byte lane where the access starts. Half and word accesses are forced
  // onto their natural boundary, so unused low address bits drop out here.
  function automatic logic [1:0] cpu_offset(input logic [1:0] size,
                                            input logic [1:0] low);
    logic [1:0] off;
    case (size)
      2'b00:   off = low;
      2'b01:   off = {low[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  // Store byte mask for a CPU access starting at lane 'off'.
  function automatic logic [3:0] cpu_store_mask(input logic [1:0] size,
                                                input logic [1:0] off);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  // The byte mask then selects the lanes that are actually written.
  function automatic logic [31:0] cpu_lane_data(input logic [1:0]  size,
                                                input logic [31:0] w);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  // Bring the addressed lanes down to bit 0 and zero-extend to the size.
  function automatic logic [31:0] cpu_align_load(input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   r = {24'h00_0000, sh[7:0]};
      2'b01:   r = {16'h0000, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  // A half access must sit on an even address; a word access on a multiple
  // of four. Byte accesses can never be misaligned.
  function automatic logic cpu_misaligned(input logic [1:0] size,
                                          input logic [1:0] low);
    logic mis;
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = low[0];
      default: mis = (low != 2'b00);
    endcase
    return mis;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t      state_q;
  state_t      state_d;
  logic [3:0]  streak_q;
  logic [3:0]  streak_d;
  logic [3:0]  streak_inc_s;

  logic        cpu_gnt_s;
  logic        dma_gnt_s;
  logic        cpu_mis_s;
  logic [1:0]  cpu_off_s;

  logic        mem_store_s;
  logic        mem_load_s;
  logic [3:0]  mem_mask_s;
  logic [31:0] mem_address_s;
  logic [31:0] mem_wdata_s;

  logic        cpu_rvalid_q;
  logic        cpu_rvalid_d;
  logic [31:0] cpu_rdata_q;
  logic [31:0] cpu_rdata_d;
  logic        dma_rvalid_q;
  logic        dma_rvalid_d;
  logic [31:0] dma_rdata_q;
  logic [31:0] dma_rdata_d;

  // DMA addresses are word granular; the byte-offset bits carry no meaning.
  logic        dma_addr_unused_s;
  assign dma_addr_unused_s = ^dma_addr[1:0];

  assign cpu_off_s    = cpu_offset(cpu_size, cpu_addr[1:0]);
  assign streak_inc_s = streak_q + 4'd1;

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  assign cpu_mis_s = cpu_misaligned(cpu_size, cpu_addr[1:0]);
`else
  assign cpu_mis_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration: grant selection and next state / streak
  // ---------------------------------------------------------------------------

  // Pick at most one winner per cycle and advance the starvation tracker.
  always_comb begin
    cpu_gnt_s = 1'b0;
    dma_gnt_s = 1'b0;
    state_d   = state_q;
    streak_d  = streak_q;

    if (rst) begin
      state_d  = S_CPU;
      streak_d = 4'd0;
    end else begin
      case (state_q)
        S_CPU: begin
          if (cpu_req) begin
            cpu_gnt_s = 1'b1;
            if (dma_req) begin
              // CPU beat a waiting DMA; once the streak hits the limit,
              // DMA owns the next contested cycle.
              streak_d = streak_inc_s;
              if (streak_inc_s == STARVE_LIMIT_C) begin
                state_d = S_FORCE_DMA;
              end else begin
                state_d = S_CPU;
              end
            end else begin
              streak_d = 4'd0;
              state_d  = S_CPU;
            end
          end else if (dma_req) begin
            dma_gnt_s = 1'b1;
            streak_d  = 4'd0;
            state_d   = S_CPU;
          end else begin
            streak_d = 4'd0;
            state_d  = S_CPU;
          end
        end
        S_FORCE_DMA: begin
          // A single forced cycle either serves DMA or lets a lone CPU
          // request through; in both cases the tracker starts over.
          state_d  = S_CPU;
          streak_d = 4'd0;
          if (dma_req) begin
            dma_gnt_s = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
          end else begin
            cpu_gnt_s = 1'b0;
          end
        end
        default: begin
          state_d  = S_CPU;
          streak_d = 4'd0;
        end
      endcase
    end
  end

  // State register and streak counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CPU;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  assign cpu_gnt   = cpu_gnt_s;
  assign dma_gnt   = dma_gnt_s;
  assign cpu_stall = cpu_req & ~cpu_gnt_s;

  // ---------------------------------------------------------------------------
  // Memory side: combinational from the winning port, all zero when idle
  // ---------------------------------------------------------------------------

  // Steer the winner's address, mask, and data onto the memory port.
  always_comb begin
    mem_store_s   = 1'b0;
    mem_load_s    = 1'b0;
    mem_mask_s    = 4'b0000;
    mem_address_s = 32'd0;
    mem_wdata_s   = 32'd0;

    if (cpu_gnt_s) begin
      if (cpu_mis_s) begin
        // Trapped access: consumed without any memory activity.
        mem_store_s = 1'b0;
        mem_load_s  = 1'b0;
      end else begin
        mem_store_s   = cpu_we;
        mem_load_s    = ~cpu_we;
        mem_address_s = {2'b00, cpu_addr[31:2]};
        mem_mask_s    = cpu_we ? cpu_store_mask(cpu_size, cpu_off_s) : 4'b1111;
        mem_wdata_s   = cpu_we ? cpu_lane_data(cpu_size, cpu_wdata) : 32'd0;
      end
    end else if (dma_gnt_s) begin
      mem_store_s   = dma_we;
      mem_load_s    = ~dma_we;
      mem_address_s = {2'b00, dma_addr[31:2]};
      mem_mask_s    = dma_we ? dma_be : 4'b1111;
      mem_wdata_s   = dma_we ? dma_wdata : 32'd0;
    end else begin
      mem_store_s = 1'b0;
      mem_load_s  = 1'b0;
    end
  end

  assign mem_store   = mem_store_s;
  assign mem_load    = mem_load_s;
  assign mem_mask    = mem_mask_s;
  assign mem_address = mem_address_s;
  assign mem_wdata   = mem_wdata_s;

  // ---------------------------------------------------------------------------
  // Load return path
  // ---------------------------------------------------------------------------

  // Capture load results at the grant edge; rdata holds between loads.
  always_comb begin
    cpu_rvalid_d = cpu_gnt_s & (~cpu_we | cpu_mis_s);
    dma_rvalid_d = dma_gnt_s & ~dma_we;

    if (cpu_gnt_s & cpu_mis_s) begin
      cpu_rdata_d = 32'd0;
    end else if (cpu_gnt_s & ~cpu_we) begin
      // The CPU result is aligned before the flop, so the registered value is
      // already the final lane-shifted, zero-extended load data.
      cpu_rdata_d = cpu_align_load(cpu_size, cpu_off_s, mem_rdata);
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end

    if (dma_gnt_s & ~dma_we) begin
      dma_rdata_d = mem_rdata;
    end else begin
      dma_rdata_d = dma_rdata_q;
    end
  end

  // Load result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= 32'd0;
    end else begin
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Reset arriving in the cycle after a load grant must swallow that pulse,
  // so the valids are also qualified by the live reset.
  assign cpu_rvalid = cpu_rvalid_q & ~rst;
  assign dma_rvalid = dma_rvalid_q & ~rst;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;

`ifdef DMEM_ARB_MISALIGN_TRAP_EN
  logic misalign_q;
  logic misalign_d;

  // Flag the cycle after a trapped access.
  always_comb begin
    misalign_d = cpu_gnt_s & cpu_mis_s;
  end

  // Misalignment pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q & ~rst;
`else
  assign misalign_err = 1'b0;
`endif

endmodule
